simon_key_expander: RTL

- Sequential SIMON64/96 key schedule. Loads a 96-bit master key and emits the 42 round keys k[0]..k[41], one per handshake beat.
- Sits directly upstream of the per-round encryption stage and drives its roundKey input.
- Computes one key word per accepted beat with a 3-word sliding window, so the full key table is never stored.

---
 rtl/simon_pkg.sv | 32 +++
 rtl/simon_key_word.sv | 21 ++
 rtl/simon_key_expander.sv | 95 +++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared constants, state type and helpers for the SIMON64/96 key schedule.
package simon_pkg;

  localparam int unsigned N      = 32;
  localparam int unsigned M      = 3;
  localparam int unsigned ROUNDS = 42;
  localparam int unsigned IdxW   = 6;

  localparam logic [N-1:0]    C_CONST = 32'hFFFF_FFFC;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ROUNDS - 1);

  // z2 sequence; the leftmost digit (bit 61) is z2[0].
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Sequence-order lookup: index 0 is the leftmost digit of the constant.
  function automatic logic z2_bit(input logic [IdxW-1:0] idx);
    logic [IdxW-1:0] pos;
    pos = IdxW'(61) - idx;
    return Z2[pos];
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int unsigned r);
    return (x >> r) | (x << (N - r));
  endfunction

endpackage

// File: rtl/simon_key_word.sv
// Combinational next-key-word generator for SIMON64/96 (m = 3 key words).
module simon_key_word
  import simon_pkg::*;
(
  input  logic [N-1:0] w0,
  input  logic [N-1:0] w2,
  input  logic         zbit,
  output logic [N-1:0] knew
);

  logic [N-1:0] r3;
  logic [N-1:0] t;

  // knew = c ^ z ^ k[i] ^ ROR3(k[i+2]) ^ ROR1(ROR3(k[i+2]))
  always_comb begin
    r3   = ror(w2, 3);
    t    = r3 ^ ror(r3, 1);
    knew = C_CONST ^ {{(N-1){1'b0}}, zbit} ^ w0 ^ t;
  end

endmodule

// File: rtl/simon_key_expander.sv
// Sequential SIMON64/96 key expander: streams k[0]..k[41] over a valid/ready
// handshake using a three-word sliding window instead of a full key table.
module simon_key_expander
  import simon_pkg::*;
(
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic [N*M-1:0]  masterKey,
  output logic [N-1:0]    roundKey,
  output logic [IdxW-1:0] roundIdx,
  output logic            keyValid,
  input  logic            keyReady,
  output logic            busy,
  output logic            done
);

  state_e          state_q;
  logic [N-1:0]    w0_q, w1_q, w2_q;
  logic [IdxW-1:0] idx_q;
  logic            key_valid_q;
  logic            busy_q;
  logic            done_q;
  logic [N-1:0]    knew;
  logic            zbit;

  assign zbit = z2_bit(idx_q);

  simon_key_word u_key_word (
    .w0   (w0_q),
    .w2   (w2_q),
    .zbit (zbit),
    .knew (knew)
  );

  // Control FSM plus window/counter; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      idx_q       <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            w0_q        <= masterKey[N-1:0];
            w1_q        <= masterKey[2*N-1:N];
            w2_q        <= masterKey[3*N-1:2*N];
            idx_q       <= '0;
            key_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (key_valid_q && keyReady) begin
            if (idx_q == LastIdx) begin
              // Window and index freeze on the final key.
              key_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              w0_q  <= w1_q;
              w1_q  <= w2_q;
              w2_q  <= knew;
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          key_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign roundKey = w0_q;
  assign roundIdx = idx_q;
  assign keyValid = key_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
